// File: rtl/fp_round_pkg.sv
// Shared types and constants for the round-to-nearest-even arbiter.
// Optional perf counters in fp_round_arbiter are enabled by FP_ROUND_PERF_EN.
package fp_round_pkg;

  localparam int MANT_W_DEF = 24;
  localparam int EXP_W_DEF  = 8;

  localparam logic [EXP_W_DEF-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    ADJUST,
    DONE
  } state_e;

  typedef struct packed {
    logic [MANT_W_DEF-1:0] mant;
    logic [EXP_W_DEF-1:0]  exp;
    logic                  r;
    logic                  s;
  } operand_t;

endpackage

// File: rtl/fp_round_core.sv
// Combinational round-half-to-even increment of a normalized mantissa.
// Carry-out of the increment signals the caller to renormalize.
module fp_round_core
  import fp_round_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic [MANT_W-1:0] mant_i,
  input  logic              r_i,
  input  logic              s_i,
  output logic [MANT_W:0]   sum_o,
  output logic              carry_o,
  output logic              inexact_o
);

  logic up;

  // Ties (R set, S clear) only round up when the LSB is odd.
  assign up        = r_i & (s_i | mant_i[0]);
  assign sum_o     = {1'b0, mant_i} + {{MANT_W{1'b0}}, up};
  assign carry_o   = sum_o[MANT_W];
  assign inexact_o = r_i | s_i;

endmodule

// File: rtl/fp_round_arbiter.sv
// Two-requester round-robin arbiter feeding a shared RNE rounding stage.
// Define FP_ROUND_PERF_EN to add ResultCount/CarryCount outputs.
module fp_round_arbiter
  import fp_round_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req0Valid,
  output logic              Req0Ready,
  input  logic [MANT_W-1:0] Req0Mant,
  input  logic [EXP_W-1:0]  Req0Exp,
  input  logic              Req0R,
  input  logic              Req0S,
  input  logic              Req1Valid,
  output logic              Req1Ready,
  input  logic [MANT_W-1:0] Req1Mant,
  input  logic [EXP_W-1:0]  Req1Exp,
  input  logic              Req1R,
  input  logic              Req1S,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [MANT_W-1:0] OutMant,
  output logic [EXP_W-1:0]  OutExp,
  output logic              OutId,
  output logic              OutOvf,
  output logic              OutInexact
`ifdef FP_ROUND_PERF_EN
  ,
  output logic [15:0]       ResultCount,
  output logic [15:0]       CarryCount
`endif
);

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  operand_t          op_q, op_d;
  logic              id_q, id_d;
  logic [MANT_W-1:0] out_mant_q, out_mant_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic              out_id_q, out_id_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_inexact_q, out_inexact_d;

  logic [MANT_W:0]   sum;
  logic              carry;
  logic              inexact;
  logic              grant1;
  logic [EXP_W-1:0]  exp_inc;

  fp_round_core #(.MANT_W(MANT_W)) u_core (
    .mant_i    (op_q.mant),
    .r_i       (op_q.r),
    .s_i       (op_q.s),
    .sum_o     (sum),
    .carry_o   (carry),
    .inexact_o (inexact)
  );

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    op_d          = op_q;
    id_d          = id_q;
    out_mant_d    = out_mant_q;
    out_exp_d     = out_exp_q;
    out_id_d      = out_id_q;
    out_ovf_d     = out_ovf_q;
    out_inexact_d = out_inexact_q;
    Req0Ready     = 1'b0;
    Req1Ready     = 1'b0;
    OutValid      = 1'b0;
    grant1        = 1'b0;
    exp_inc       = op_q.exp + EXP_W'(1);

    case (state_q)
      IDLE: begin
        if (Req0Valid || Req1Valid) begin
          // A lone requester wins outright; on contention rr picks.
          grant1    = Req1Valid & (~Req0Valid | rr_q);
          Req1Ready = grant1;
          Req0Ready = ~grant1;
          op_d      = grant1 ? '{mant: Req1Mant, exp: Req1Exp, r: Req1R, s: Req1S}
                             : '{mant: Req0Mant, exp: Req0Exp, r: Req0R, s: Req0S};
          id_d      = grant1;
          state_d   = ROUND;
        end
      end
      ROUND: begin
        out_id_d      = id_q;
        out_inexact_d = inexact;
        out_ovf_d     = 1'b0;
        out_exp_d     = op_q.exp;
        if (op_q.exp == EXP_MAX) begin
          out_mant_d = '0;
          out_ovf_d  = 1'b1;
          state_d    = DONE;
        end else if (carry) begin
          state_d = ADJUST;
        end else begin
          out_mant_d = sum[MANT_W-1:0];
          state_d    = DONE;
        end
      end
      ADJUST: begin
        out_exp_d = exp_inc;
        if (exp_inc == EXP_MAX) begin
          out_mant_d = '0;
          out_ovf_d  = 1'b1;
        end else begin
          out_mant_d = sum[MANT_W:1];
        end
        state_d = DONE;
      end
      DONE: begin
        OutValid = 1'b1;
        if (OutReady) begin
          rr_d    = ~out_id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (Reset) begin
      Req0Ready = 1'b0;
      Req1Ready = 1'b0;
      OutValid  = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= IDLE;
      rr_q          <= 1'b0;
      out_mant_q    <= '0;
      out_exp_q     <= '0;
      out_id_q      <= 1'b0;
      out_ovf_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      out_mant_q    <= out_mant_d;
      out_exp_q     <= out_exp_d;
      out_id_q      <= out_id_d;
      out_ovf_q     <= out_ovf_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  // Captured operand only matters once ROUND is entered, so it carries no reset.
  always_ff @(posedge Clock) begin
    op_q <= op_d;
    id_q <= id_d;
  end

  assign OutMant    = out_mant_q;
  assign OutExp     = out_exp_q;
  assign OutId      = out_id_q;
  assign OutOvf     = out_ovf_q;
  assign OutInexact = out_inexact_q;

`ifdef FP_ROUND_PERF_EN
  logic [15:0] result_cnt_q, carry_cnt_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      result_cnt_q <= '0;
      carry_cnt_q  <= '0;
    end else begin
      if (OutValid && OutReady) result_cnt_q <= result_cnt_q + 16'd1;
      if (state_q == ROUND && state_d == ADJUST) carry_cnt_q <= carry_cnt_q + 16'd1;
    end
  end

  assign ResultCount = result_cnt_q;
  assign CarryCount  = carry_cnt_q;
`endif

endmodule

// File: tb/tb_fp_round_arbiter.sv
// Scoreboard bench for fp_round_arbiter: directed operands, arbitration, backpressure, reset.
module tb_fp_round_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Req0Valid, Req1Valid;
  logic        Req0Ready, Req1Ready;
  logic [23:0] Req0Mant, Req1Mant;
  logic [7:0]  Req0Exp, Req1Exp;
  logic        Req0R, Req0S, Req1R, Req1S;
  logic        OutValid, OutReady;
  logic [23:0] OutMant;
  logic [7:0]  OutExp;
  logic        OutId, OutOvf, OutInexact;
`ifdef FP_ROUND_PERF_EN
  logic [15:0] ResultCount, CarryCount;
`endif

  fp_round_arbiter dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Req0Valid  (Req0Valid),
    .Req0Ready  (Req0Ready),
    .Req0Mant   (Req0Mant),
    .Req0Exp    (Req0Exp),
    .Req0R      (Req0R),
    .Req0S      (Req0S),
    .Req1Valid  (Req1Valid),
    .Req1Ready  (Req1Ready),
    .Req1Mant   (Req1Mant),
    .Req1Exp    (Req1Exp),
    .Req1R      (Req1R),
    .Req1S      (Req1S),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutMant    (OutMant),
    .OutExp     (OutExp),
    .OutId      (OutId),
    .OutOvf     (OutOvf),
    .OutInexact (OutInexact)
`ifdef FP_ROUND_PERF_EN
    ,
    .ResultCount(ResultCount),
    .CarryCount (CarryCount)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [63:0] val;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   in_done = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic logic [63:0] pack(input logic id, input logic ovf, input logic inx,
                                       input logic [7:0] e, input logic [23:0] m);
    return {29'd0, id, ovf, inx, e, m};
  endfunction

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  task automatic push(input logic id, input logic [23:0] xm, input logic [7:0] xe,
                      input logic xovf, input logic xinx, input int lat);
    exp_t e;
    e.val = pack(id, xovf, xinx, xe, xm);
    e.lat = lat;
    e.acc = cyc;
    sb.push_back(e);
  endtask

  // Monitor: latency on first OutValid, field compare on the handshake.
  always @(negedge Clock) begin
    logic [63:0] act;
    exp_t e;
    act = pack(OutId, OutOvf, OutInexact, OutExp, OutMant);
    if (Reset) begin
      in_done <= 1'b0;
    end else if (OutValid) begin
      if (sb.size() == 0) begin
        if (OutReady) chk("unexpected_result", 1'b0, act, 64'd0);
      end else begin
        if (!in_done) begin
          in_done <= 1'b1;
          chk("latency", (cyc - sb[0].acc) == sb[0].lat, 64'(cyc - sb[0].acc), 64'(sb[0].lat));
        end
        if (OutReady) begin
          e = sb.pop_front();
          chk("result", act == e.val, act, e.val);
          in_done <= 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic id, input logic v, input logic [23:0] m, input logic [7:0] e,
                       input logic r, input logic s);
    if (id) begin
      Req1Valid = v; Req1Mant = m; Req1Exp = e; Req1R = r; Req1S = s;
    end else begin
      Req0Valid = v; Req0Mant = m; Req0Exp = e; Req0R = r; Req0S = s;
    end
  endtask

  task automatic issue(input logic id, input logic [23:0] m, input logic [7:0] e, input logic r,
                       input logic s, input logic [23:0] xm, input logic [7:0] xe,
                       input logic xovf, input logic xinx, input int lat);
    bit got = 1'b0;
    @(posedge Clock); #1;
    drive(id, 1'b1, m, e, r, s);
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge Clock);
      if (id ? Req1Ready : Req0Ready) begin
        got = 1'b1;
        push(id, xm, xe, xovf, xinx, lat);
      end
    end
    if (!got) chk("grant_timeout", 1'b0, 64'd0, 64'd1);
    @(posedge Clock); #1;
    drive(id, 1'b0, m, e, r, s);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge Clock);
    chk("drain", sb.size() == 0, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   grants[3];
    int   ng;
    bit   got;
    logic [63:0] snap, cur;

    Reset = 1'b1;
    OutReady = 1'b1;
    drive(1'b0, 1'b1, 24'h800001, 8'h10, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 24'h800005, 8'h20, 1'b0, 1'b1);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("reset_ready", {Req0Ready, Req1Ready} == 2'b00, 64'({Req0Ready, Req1Ready}), 64'd0);
    chk("reset_outvalid", OutValid == 1'b0, 64'(OutValid), 64'd0);
    chk("reset_outfields", pack(OutId, OutOvf, OutInexact, OutExp, OutMant) == 64'd0,
        pack(OutId, OutOvf, OutInexact, OutExp, OutMant), 64'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;

    // Both requesters held valid from reset: grants must alternate 0,1,0.
    ng = 0;
    for (int k = 0; k < 60 && ng < 3; k++) begin
      @(negedge Clock);
      if (Req0Ready && Req1Ready) chk("double_grant", 1'b0, 64'd3, 64'd1);
      else if (Req0Ready) begin
        push(1'b0, 24'h800002, 8'h10, 1'b0, 1'b1, 2);
        grants[ng] = 0; ng++;
      end else if (Req1Ready) begin
        push(1'b1, 24'h800005, 8'h20, 1'b0, 1'b1, 2);
        grants[ng] = 1; ng++;
      end
    end
    @(posedge Clock); #1;
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    chk("grant_count", ng == 3, 64'(ng), 64'd3);
    chk("grant0", grants[0] == 0, 64'(grants[0]), 64'd0);
    chk("grant1", grants[1] == 1, 64'(grants[1]), 64'd1);
    chk("grant2", grants[2] == 0, 64'(grants[2]), 64'd0);
    drain();

    // Directed rounding vectors.
    issue(1'b0, 24'h800003, 8'h7F, 1'b1, 1'b0, 24'h800004, 8'h7F, 1'b0, 1'b1, 2);
    issue(1'b1, 24'h800002, 8'h40, 1'b1, 1'b0, 24'h800002, 8'h40, 1'b0, 1'b1, 2);
    issue(1'b0, 24'hFFFFFF, 8'h7F, 1'b1, 1'b1, 24'h800000, 8'h80, 1'b0, 1'b1, 3);
    issue(1'b0, 24'hFFFFFF, 8'hFE, 1'b1, 1'b1, 24'h000000, 8'hFF, 1'b1, 1'b1, 3);
    issue(1'b1, 24'h812345, 8'hFF, 1'b0, 1'b0, 24'h000000, 8'hFF, 1'b1, 1'b0, 2);
    issue(1'b0, 24'h000001, 8'h00, 1'b1, 1'b0, 24'h000002, 8'h00, 1'b0, 1'b1, 2);
    issue(1'b1, 24'hABCDEF, 8'h55, 1'b0, 1'b0, 24'hABCDEF, 8'h55, 1'b0, 1'b0, 2);
    issue(1'b1, 24'h800001, 8'h33, 1'b1, 1'b0, 24'h800002, 8'h33, 1'b0, 1'b1, 2);
    drain();

    // Backpressure: hold DONE with a competing request pending.
    OutReady = 1'b0;
    issue(1'b0, 24'h900001, 8'h20, 1'b1, 1'b1, 24'h900002, 8'h20, 1'b0, 1'b1, 2);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge Clock);
      got = OutValid;
    end
    chk("bp_valid", got, 64'(got), 64'd1);
    snap = pack(OutId, OutOvf, OutInexact, OutExp, OutMant);
    drive(1'b1, 1'b1, 24'hC00000, 8'h30, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      cur = pack(OutId, OutOvf, OutInexact, OutExp, OutMant);
      chk("bp_hold", (cur == snap) && OutValid, cur, snap);
      chk("bp_ready", {Req0Ready, Req1Ready} == 2'b00, 64'({Req0Ready, Req1Ready}), 64'd0);
    end
    @(posedge Clock); #1;
    OutReady = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    chk("bp_idle_valid", OutValid == 1'b0, 64'(OutValid), 64'd0);
    chk("bp_idle_grant", Req1Ready == 1'b1, 64'(Req1Ready), 64'd1);
    if (Req1Ready) push(1'b1, 24'hC00000, 8'h30, 1'b0, 1'b0, 2);
    @(posedge Clock); #1;
    Req1Valid = 1'b0;
    drain();

    // Leave rr pointing at requester 1, then reset mid-ROUND.
    issue(1'b0, 24'h800000, 8'h01, 1'b0, 1'b0, 24'h800000, 8'h01, 1'b0, 1'b0, 2);
    drain();
    issue(1'b1, 24'h800007, 8'h12, 1'b1, 1'b0, 24'h800008, 8'h12, 1'b0, 1'b1, 2);
    Reset = 1'b1;
    sb.delete();
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst_outvalid", OutValid == 1'b0, 64'(OutValid), 64'd0);
    chk("rst_outfields", pack(OutId, OutOvf, OutInexact, OutExp, OutMant) == 64'd0,
        pack(OutId, OutOvf, OutInexact, OutExp, OutMant), 64'd0);
    got = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      got = got | OutValid;
    end
    chk("rst_discard", got == 1'b0, 64'(got), 64'd0);
    @(posedge Clock); #1;
    drive(1'b0, 1'b1, 24'hA00001, 8'h44, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 24'hB00000, 8'h45, 1'b0, 1'b0);
    @(negedge Clock);
    chk("rst_rr_grant", {Req1Ready, Req0Ready} == 2'b01, 64'({Req1Ready, Req0Ready}), 64'd1);
    if (Req0Ready) push(1'b0, 24'hA00002, 8'h44, 1'b0, 1'b1, 2);
    @(posedge Clock); #1;
    Req0Valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge Clock);
      if (Req1Ready) begin
        got = 1'b1;
        push(1'b1, 24'hB00000, 8'h45, 1'b0, 1'b0, 2);
      end
    end
    chk("rst_second_grant", got, 64'(got), 64'd1);
    @(posedge Clock); #1;
    Req1Valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
